// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared encodings and instruction field positions for the
//            multi-cycle MIPS control unit and datapath.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU     = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP    = 2'b10;
  localparam logic [1:0] PCSRC_ALU_ALT = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int JADDR_HI = 25;

  // Unsupported control codes yield zero rather than an arbitrary result.
  function automatic logic [31:0] alu_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] ctl);
    logic [31:0] res;
    res = '0;
    case (ctl)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_SLT: res = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_datapath_regfile.sv
// ============================================================================
// regfile : 32 x 32 register file, two combinational read ports, one write
//           port, register 0 hard-wired to zero, asynchronous clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  input  logic [4:0]       wa,
  input  logic             we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);

  logic [WIDTH-1:0] r_regs [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      r_regs[wa] <= wd;
    end
  end

  // No write bypass: a same-cycle read sees the pre-write contents.
  assign rd1 = (ra1 == 5'd0) ? '0 : r_regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : r_regs[ra2];

endmodule

`default_nettype wire

// File: rtl/mc_datapath.sv
// ============================================================================
// mc_datapath : multi-cycle MIPS datapath holding PC, IR, MDR, A, B, ALUOut
//               and the register file; executes control-unit micro-ops.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mc_datapath
  import mips_pkg::*;
#(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemtoReg,
  input  logic             RegDst,
  input  logic             IorD,
  input  logic             ALUSrcA,
  input  logic [1:0]       PCSrc,
  input  logic [1:0]       ALUSrcB,
  input  logic             IRWrite,
  input  logic             RegWrite,
  input  logic             PCEn,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] ReadData,
  output logic [WIDTH-1:0] Adr,
  output logic [WIDTH-1:0] WriteData,
  output logic [5:0]       OPCode,
  output logic [5:0]       Funct,
  output logic             Zero
);

  logic [WIDTH-1:0] r_pc, r_ir, r_data, r_a, r_b, r_aluout;
  logic [WIDTH-1:0] w_rd1, w_rd2, w_wd, w_sign_imm, w_jump;
  logic [WIDTH-1:0] w_src_a, w_src_b, w_alu_result, w_pc_next;
  logic [4:0]       w_wa;

  assign w_wa       = RegDst ? r_ir[RD_HI:RD_LO] : r_ir[RT_HI:RT_LO];
  assign w_wd       = MemtoReg ? r_data : r_aluout;
  assign w_sign_imm = {{16{r_ir[IMM_HI]}}, r_ir[IMM_HI:0]};
  assign w_jump     = {r_pc[31:28], r_ir[JADDR_HI:0], 2'b00};

  regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (r_ir[RS_HI:RS_LO]),
    .ra2   (r_ir[RT_HI:RT_LO]),
    .wa    (w_wa),
    .we    (RegWrite),
    .wd    (w_wd),
    .rd1   (w_rd1),
    .rd2   (w_rd2)
  );

  always_comb begin
    w_src_a = ALUSrcA ? r_a : r_pc;
    case (ALUSrcB)
      SRCB_REG:  w_src_b = r_b;
      SRCB_FOUR: w_src_b = 32'd4;
      SRCB_IMM:  w_src_b = w_sign_imm;
      default:   w_src_b = {w_sign_imm[WIDTH-3:0], 2'b00};
    endcase
    w_alu_result = alu_op(w_src_a, w_src_b, ALUControl);
    case (PCSrc)
      PCSRC_ALUOUT: w_pc_next = r_aluout;
      PCSRC_JUMP:   w_pc_next = w_jump;
      default:      w_pc_next = w_alu_result;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_data   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
    end else begin
      if (PCEn)    r_pc <= w_pc_next;
      if (IRWrite) r_ir <= ReadData;
      r_data   <= ReadData;
      r_a      <= w_rd1;
      r_b      <= w_rd2;
      r_aluout <= w_alu_result;
    end
  end

  assign Adr       = IorD ? r_aluout : r_pc;
  assign WriteData = r_b;
  assign OPCode    = r_ir[OP_HI:OP_LO];
  assign Funct     = r_ir[FUNCT_HI:FUNCT_LO];
  assign Zero      = (w_alu_result == '0);

endmodule

`default_nettype wire
